// File: rtl/vga_timing_pkg.sv
// Shared raster constants, counter widths and the visible-area decode
// used by both the current-position and lookahead paths.
package vga_timing_pkg;

    localparam int unsigned H_W = 11;
    localparam int unsigned V_W = 10;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    function automatic logic is_active(input logic [H_W-1:0] h, input logic [V_W-1:0] v,
                                       input int unsigned h_active, input int unsigned v_active);
        return (32'(h) < h_active) && (32'(v) < v_active);
    endfunction

endpackage

// File: rtl/vga_position_counter.sv
// Row-major h/v wrap counter with a configurable reset position.
// The next position is exported so the owner can register its decode on the same edge.
module vga_position_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL = DEF_H_TOTAL,
    parameter int unsigned V_TOTAL = DEF_V_TOTAL,
    parameter int unsigned RST_H   = DEF_H_TOTAL - 1,
    parameter int unsigned RST_V   = DEF_V_TOTAL - 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           step,
    output logic [H_W-1:0] h,
    output logic [V_W-1:0] v,
    output logic [H_W-1:0] h_next_c,
    output logic [V_W-1:0] v_next_c
);

    always_comb begin
        h_next_c = h;
        v_next_c = v;
        if (rst) begin
            h_next_c = H_W'(RST_H);
            v_next_c = V_W'(RST_V);
        end else if (step) begin
            if (h == H_W'(H_TOTAL - 1)) begin
                h_next_c = '0;
                v_next_c = (v == V_W'(V_TOTAL - 1)) ? '0 : v + V_W'(1);
            end else begin
                h_next_c = h + H_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= H_W'(RST_H);
            v <= V_W'(RST_V);
        end else begin
            h <= h_next_c;
            v <= v_next_c;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// Raster timing source: position counters, sync/visible decode and a
// lookahead fetch window that leads the visible area by FETCH_LEAD pixels.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter logic        HSYNC_POL  = 1'b0,
    parameter logic        VSYNC_POL  = 1'b0,
    parameter int unsigned FETCH_LEAD = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pixelEn,
    output logic [H_W-1:0] horizontalCount,
    output logic [V_W-1:0] verticalCount,
    output logic           HSYNC,
    output logic           VSYNC,
    output logic           displayActive,
    output logic           vblank,
    output logic           evenOrOdd,
    output logic           frameEnd
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Lookahead reset is the current reset position advanced by FETCH_LEAD (wraps into line 0).
    localparam int unsigned LA_RST_H = (FETCH_LEAD == 0) ? H_TOTAL - 1 : FETCH_LEAD - 1;
    localparam int unsigned LA_RST_V = (FETCH_LEAD == 0) ? V_TOTAL - 1 : 0;

    if (FETCH_LEAD >= H_FP + H_SYNC + H_BP) begin : g_bad_lead
        $error("FETCH_LEAD must be below the horizontal blanking width");
    end
    if (H_TOTAL >= 2048) begin : g_bad_h_total
        $error("H_TOTAL must be below 2048");
    end
    if (V_TOTAL >= 1024) begin : g_bad_v_total
        $error("V_TOTAL must be below 1024");
    end

    logic [H_W-1:0] cur_h_nx;
    logic [V_W-1:0] cur_v_nx;
    logic [H_W-1:0] la_h_nx;
    logic [V_W-1:0] la_v_nx;
    logic [H_W-1:0] la_h_unused;
    logic [V_W-1:0] la_v_unused;

    vga_position_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .RST_H   (H_TOTAL - 1),
        .RST_V   (V_TOTAL - 1)
    ) u_cur (
        .clk      (clk),
        .rst      (rst),
        .step     (pixelEn),
        .h        (horizontalCount),
        .v        (verticalCount),
        .h_next_c (cur_h_nx),
        .v_next_c (cur_v_nx)
    );

    vga_position_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .RST_H   (LA_RST_H),
        .RST_V   (LA_RST_V)
    ) u_lookahead (
        .clk      (clk),
        .rst      (rst),
        .step     (pixelEn),
        .h        (la_h_unused),
        .v        (la_v_unused),
        .h_next_c (la_h_nx),
        .v_next_c (la_v_nx)
    );

    // Decode the position the counters are about to hold, so flags land on the same edge.
    always_ff @(posedge clk) begin
        HSYNC         <= ((32'(cur_h_nx) >= HS_START) && (32'(cur_h_nx) < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        VSYNC         <= ((32'(cur_v_nx) >= VS_START) && (32'(cur_v_nx) < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        displayActive <= is_active(cur_h_nx, cur_v_nx, H_ACTIVE, V_ACTIVE);
        vblank        <= is_active(la_h_nx, la_v_nx, H_ACTIVE, V_ACTIVE);
        evenOrOdd     <= cur_v_nx[0];
        frameEnd      <= (cur_h_nx == H_W'(H_ACTIVE)) && (cur_v_nx == V_W'(V_ACTIVE - 1));
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: four raster configurations share one stimulus stream;
// a reference model feeds a queue and a negedge monitor compares.
module tb_vga_timing_generator;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        da;
        logic        vb;
        logic        eo;
        logic        fe;
    } obs_t;

    typedef obs_t [3:0] exp4_t;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        int fl;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        int         h;
        int         v;
        logic [5:0] bits;
    } probe_t;

    localparam int NPROBE = 13;

    logic clk;
    logic rst;
    logic pixel_en;

    logic [10:0] hc [4];
    logic [9:0]  vc [4];
    logic        hs [4];
    logic        vs [4];
    logic        da [4];
    logic        vb [4];
    logic        eo [4];
    logic        fe [4];

    cfg_t   cfg [4];
    int     mh  [4];
    int     mv  [4];
    exp4_t  sb [$];
    probe_t probes [NPROBE];
    bit     probe_hit [NPROBE];
    bit     done;
    int     total;
    int     bad;
    int     cyc;
    exp4_t  e;
    obs_t   a;

    vga_timing_generator u_dut_def (
        .clk(clk), .rst(rst), .pixelEn(pixel_en),
        .horizontalCount(hc[0]), .verticalCount(vc[0]), .HSYNC(hs[0]), .VSYNC(vs[0]),
        .displayActive(da[0]), .vblank(vb[0]), .evenOrOdd(eo[0]), .frameEnd(fe[0])
    );

    vga_timing_generator #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .FETCH_LEAD(2)
    ) u_dut_mid (
        .clk(clk), .rst(rst), .pixelEn(pixel_en),
        .horizontalCount(hc[1]), .verticalCount(vc[1]), .HSYNC(hs[1]), .VSYNC(vs[1]),
        .displayActive(da[1]), .vblank(vb[1]), .evenOrOdd(eo[1]), .frameEnd(fe[1])
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .FETCH_LEAD(0)
    ) u_dut_small0 (
        .clk(clk), .rst(rst), .pixelEn(pixel_en),
        .horizontalCount(hc[2]), .verticalCount(vc[2]), .HSYNC(hs[2]), .VSYNC(vs[2]),
        .displayActive(da[2]), .vblank(vb[2]), .evenOrOdd(eo[2]), .frameEnd(fe[2])
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .FETCH_LEAD(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) u_dut_small3 (
        .clk(clk), .rst(rst), .pixelEn(pixel_en),
        .horizontalCount(hc[3]), .verticalCount(vc[3]), .HSYNC(hs[3]), .VSYNC(vs[3]),
        .displayActive(da[3]), .vblank(vb[3]), .evenOrOdd(eo[3]), .frameEnd(fe[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int htot(input cfg_t c);
        return c.ha + c.hfp + c.hsw + c.hbp;
    endfunction

    function automatic int vtot(input cfg_t c);
        return c.va + c.vfp + c.vsw + c.vbp;
    endfunction

    // Expected outputs straight from the raster definitions (linear index for the lead).
    function automatic obs_t model(input cfg_t c, input int h, input int v);
        obs_t o;
        int ht, vt, idx, lh, lv;
        ht   = htot(c);
        vt   = vtot(c);
        o.h  = 11'(h);
        o.v  = 10'(v);
        o.hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hp : ~c.hp;
        o.vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vp : ~c.vp;
        o.da = 1'((h < c.ha) && (v < c.va));
        idx  = (v * ht + h + c.fl) % (ht * vt);
        lh   = idx % ht;
        lv   = idx / ht;
        o.vb = 1'((lh < c.ha) && (lv < c.va));
        o.eo = 1'((v % 2) == 1);
        o.fe = 1'((h == c.ha) && (v == c.va - 1));
        return o;
    endfunction

    task automatic drive(input bit r, input bit en);
        exp4_t x;
        rst      = r;
        pixel_en = en;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                mh[i] = htot(cfg[i]) - 1;
                mv[i] = vtot(cfg[i]) - 1;
            end else if (en) begin
                if (mh[i] == htot(cfg[i]) - 1) begin
                    mh[i] = 0;
                    mv[i] = (mv[i] == vtot(cfg[i]) - 1) ? 0 : mv[i] + 1;
                end else begin
                    mh[i] = mh[i] + 1;
                end
            end
            x[i] = model(cfg[i], mh[i], mv[i]);
        end
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic set_probe(input int k, input int h, input int v, input logic [5:0] bits);
        probes[k].h    = h;
        probes[k].v    = v;
        probes[k].bits = bits;
    endtask

    // Monitor: pop one expectation per cycle, compare every instance, then hand-computed probes.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cyc++;
            for (int i = 0; i < 4; i++) begin
                a.h  = hc[i];
                a.v  = vc[i];
                a.hs = hs[i];
                a.vs = vs[i];
                a.da = da[i];
                a.vb = vb[i];
                a.eo = eo[i];
                a.fe = fe[i];
                total++;
                if (a !== e[i]) begin
                    bad++;
                    $display("FAIL raster inst%0d cyc%0d got h=%0d v=%0d hs,vs,da,vb,eo,fe=%b%b%b%b%b%b want h=%0d v=%0d hs,vs,da,vb,eo,fe=%b%b%b%b%b%b",
                             i, cyc, a.h, a.v, a.hs, a.vs, a.da, a.vb, a.eo, a.fe,
                             e[i].h, e[i].v, e[i].hs, e[i].vs, e[i].da, e[i].vb, e[i].eo, e[i].fe);
                end
            end
            for (int k = 0; k < NPROBE; k++) begin
                if (!probe_hit[k] && int'(e[0].h) == probes[k].h && int'(e[0].v) == probes[k].v) begin
                    probe_hit[k] = 1'b1;
                    total++;
                    if (hc[0] !== 11'(probes[k].h) || vc[0] !== 10'(probes[k].v) ||
                        {hs[0], vs[0], da[0], vb[0], eo[0], fe[0]} !== probes[k].bits) begin
                        bad++;
                        $display("FAIL probe(%0d,%0d) got h=%0d v=%0d hs,vs,da,vb,eo,fe=%b%b%b%b%b%b want %b",
                                 probes[k].h, probes[k].v, hc[0], vc[0],
                                 hs[0], vs[0], da[0], vb[0], eo[0], fe[0], probes[k].bits);
                    end
                end
            end
        end else if (done) begin
            for (int k = 0; k < NPROBE; k++) begin
                total++;
                if (!probe_hit[k]) begin
                    bad++;
                    $display("FAIL probe_reached(%0d,%0d) got unvisited want visited", probes[k].h, probes[k].v);
                end
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        int n;
        total    = 0;
        bad      = 0;
        cyc      = 0;
        done     = 1'b0;
        rst      = 1'b1;
        pixel_en = 1'b0;
        cfg[0] = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33, fl:2, hp:1'b0, vp:1'b0};
        cfg[1] = '{ha:64,  hfp:4,  hsw:8,  hbp:4,  va:48,  vfp:2,  vsw:2, vbp:3,  fl:2, hp:1'b0, vp:1'b0};
        cfg[2] = '{ha:8,   hfp:2,  hsw:2,  hbp:2,  va:4,   vfp:1,  vsw:1, vbp:1,  fl:0, hp:1'b0, vp:1'b0};
        cfg[3] = '{ha:8,   hfp:2,  hsw:2,  hbp:2,  va:4,   vfp:1,  vsw:1, vbp:1,  fl:3, hp:1'b1, vp:1'b1};
        for (int i = 0; i < 4; i++) begin
            mh[i] = 0;
            mv[i] = 0;
        end
        // Hand-computed default-raster points: bits are {HSYNC,VSYNC,displayActive,vblank,evenOrOdd,frameEnd}.
        set_probe(0,  799, 524, 6'b110100);
        set_probe(1,  0,   0,   6'b111100);
        set_probe(2,  637, 0,   6'b111100);
        set_probe(3,  638, 0,   6'b111000);
        set_probe(4,  639, 0,   6'b111000);
        set_probe(5,  640, 0,   6'b110000);
        set_probe(6,  656, 0,   6'b010000);
        set_probe(7,  751, 0,   6'b010000);
        set_probe(8,  752, 0,   6'b110000);
        set_probe(9,  797, 0,   6'b110000);
        set_probe(10, 798, 0,   6'b110100);
        set_probe(11, 0,   1,   6'b111110);
        set_probe(12, 655, 1,   6'b110010);

        @(negedge clk);
        repeat (3) drive(1'b1, 1'b1);
        repeat (10000) drive(1'b0, 1'b1);
        for (int i = 0; i < 9000; i++) drive(1'b0, (i % 3) == 0);
        // Walk the mid raster into its VSYNC lines, then reset in the middle of the pulse.
        n = 0;
        while (!(mh[1] == 70 && mv[1] == 50) && n < 5000) begin
            drive(1'b0, 1'b1);
            n++;
        end
        drive(1'b1, 1'b1);
        repeat (5000) drive(1'b0, 1'b1);
        done = 1'b1;
    end

endmodule
